// File: rtl/romulus_round_ctrl.sv
// SKINNY-128-384+ round sequencer for the Romulus datapath: round constant, phase ring and register enables.
// Optional build macro ROUND_CTRL_CORRECT_EN adds the CORRECT state that restores tweakey/counter after a call.
module romulus_round_ctrl #(
   parameter int ROUNDS       = 40,
   parameter int CLKS_PER_RND = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    inc_cnt,
   output logic                    busy,
   output logic                    done,
   output logic [5:0]              round,
   output logic [5:0]              constant,
   output logic [CLKS_PER_RND-1:0] ring_en,
   output logic                    senc,
   output logic                    xenc,
   output logic                    yenc,
   output logic                    zenc,
   output logic                    sen,
   output logic                    xen,
   output logic                    yen,
   output logic                    zen,
   output logic                    correct_cnt
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
`ifdef ROUND_CTRL_CORRECT_EN
      S_CORRECT = 2'd2,
`endif
      S_DONE    = 2'd3
   } state_t;

   localparam logic [5:0]              LAST_RND      = 6'(ROUNDS - 1);
   localparam logic [CLKS_PER_RND-1:0] RING_FIRST    = CLKS_PER_RND'(1);
   localparam logic                    FIRST_IS_LAST = (CLKS_PER_RND == 1);

   state_t                  state_q;
   logic [5:0]              round_q, round_d;
   logic [5:0]              rc_q, rc_d;
   logic [CLKS_PER_RND-1:0] ring_q, ring_d;
   logic                    busy_q, done_q, enc_q, sen_q, xyz_q;
   logic                    last_phase;
`ifdef ROUND_CTRL_CORRECT_EN
   logic                    ccnt_q;
`endif

   // SKINNY 6-bit LFSR round-constant update
   assign rc_d       = {rc_q[4:0], rc_q[5] ^ rc_q[4] ^ 1'b1};
   assign round_d    = round_q + 6'd1;
   assign last_phase = ring_q[CLKS_PER_RND-1];

   generate
      if (CLKS_PER_RND == 1) begin : g_ring_single
         assign ring_d = ring_q;
      end else begin : g_ring_rot
         assign ring_d = {ring_q[CLKS_PER_RND-2:0], ring_q[CLKS_PER_RND-1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         round_q <= '0;
         rc_q    <= '0;
         ring_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         enc_q   <= 1'b0;
         sen_q   <= 1'b0;
         xyz_q   <= 1'b0;
`ifdef ROUND_CTRL_CORRECT_EN
         ccnt_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_RUN;
                  round_q <= '0;
                  rc_q    <= 6'h01;
                  ring_q  <= RING_FIRST;
                  busy_q  <= 1'b1;
                  enc_q   <= 1'b1;
                  sen_q   <= FIRST_IS_LAST;
                  xyz_q   <= FIRST_IS_LAST;
               end
            end
            S_RUN: begin
               if (last_phase && (round_q == LAST_RND)) begin
                  ring_q  <= '0;
                  enc_q   <= 1'b0;
                  sen_q   <= 1'b0;
`ifdef ROUND_CTRL_CORRECT_EN
                  state_q <= S_CORRECT;
                  xyz_q   <= 1'b1;
                  ccnt_q  <= inc_cnt;
`else
                  state_q <= S_DONE;
                  xyz_q   <= 1'b0;
                  done_q  <= 1'b1;
`endif
               end else begin
                  ring_q <= ring_d;
                  sen_q  <= ring_d[CLKS_PER_RND-1];
                  xyz_q  <= ring_d[CLKS_PER_RND-1];
                  if (last_phase) begin
                     round_q <= round_d;
                     rc_q    <= rc_d;
                  end
               end
            end
`ifdef ROUND_CTRL_CORRECT_EN
            S_CORRECT: begin
               state_q <= S_DONE;
               xyz_q   <= 1'b0;
               ccnt_q  <= 1'b0;
               done_q  <= 1'b1;
            end
`endif
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               round_q <= '0;
               rc_q    <= '0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign round    = round_q;
   assign constant = rc_q;
   assign ring_en  = ring_q;
   assign senc     = enc_q;
   assign xenc     = enc_q;
   assign yenc     = enc_q;
   assign zenc     = enc_q;
   assign sen      = sen_q;
   assign xen      = xyz_q;
   assign yen      = xyz_q;
   assign zen      = xyz_q;

`ifdef ROUND_CTRL_CORRECT_EN
   assign correct_cnt = ccnt_q;
`else
   logic unused_inc_cnt;
   assign unused_inc_cnt = inc_cnt;
   assign correct_cnt    = 1'b0;
`endif

endmodule

// File: tb/tb_romulus_round_ctrl.sv
// Scoreboard bench for romulus_round_ctrl: default instance (1 phase/round) and a 4-phase instance.
module tb_romulus_round_ctrl;

   localparam int ROUNDS = 40;
`ifdef ROUND_CTRL_CORRECT_EN
   localparam int EXTRA = 2;
`else
   localparam int EXTRA = 1;
`endif
   localparam int LAT0 = ROUNDS + EXTRA;
   localparam int LAT1 = ROUNDS * 4 + EXTRA;

   typedef struct {
      int   st;
      logic inc;
   } txn_t;

   logic clk = 1'b0;
   logic rst;
   logic start0, inc0, start1, inc1;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   logic       busy0, done0, senc0, xenc0, yenc0, zenc0, sen0, xen0, yen0, zen0, ccnt0;
   logic [5:0] round0, const0;
   logic [0:0] ring0;
   logic       busy1, done1, senc1, xenc1, yenc1, zenc1, sen1, xen1, yen1, zen1, ccnt1;
   logic [5:0] round1, const1;
   logic [3:0] ring1;

   logic [23:0] outs0;
   logic [26:0] outs1;
   assign outs0 = {busy0, done0, round0, const0, ring0, senc0, xenc0, yenc0, zenc0,
                   sen0, xen0, yen0, zen0, ccnt0};
   assign outs1 = {busy1, done1, round1, const1, ring1, senc1, xenc1, yenc1, zenc1,
                   sen1, xen1, yen1, zen1, ccnt1};

   txn_t       q0[$];
   logic [5:0] rc_tab[ROUNDS];
   int         run_sen = 0;
   int         mk;

   romulus_round_ctrl #(.ROUNDS(ROUNDS), .CLKS_PER_RND(1)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .inc_cnt(inc0),
      .busy(busy0), .done(done0), .round(round0), .constant(const0), .ring_en(ring0),
      .senc(senc0), .xenc(xenc0), .yenc(yenc0), .zenc(zenc0),
      .sen(sen0), .xen(xen0), .yen(yen0), .zen(zen0), .correct_cnt(ccnt0)
   );

   romulus_round_ctrl #(.ROUNDS(ROUNDS), .CLKS_PER_RND(4)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .inc_cnt(inc1),
      .busy(busy1), .done(done1), .round(round1), .constant(const1), .ring_en(ring1),
      .senc(senc1), .xenc(xenc1), .yenc(yenc1), .zenc(zenc1),
      .sen(sen1), .xen(xen1), .yen(yen1), .zen(zen1), .correct_cnt(ccnt1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic push_txn(input int st, input logic inc);
      txn_t t;
      t.st  = st;
      t.inc = inc;
      q0.push_back(t);
   endtask

   initial begin
      logic [5:0] r;
      r = 6'h01;
      for (int i = 0; i < ROUNDS; i++) begin
         rc_tab[i] = r;
         r = {r[4:0], r[5] ^ r[4] ^ 1'b1};
      end
   end

   // Scoreboard monitor for the default instance
   always @(negedge clk) begin
      if (!busy0) run_sen = 0;
      else if (sen0) run_sen = run_sen + 1;
      if (ccnt0 && !u_dut0.busy) chk("ccnt_idle", ccnt0, 0);
`ifndef ROUND_CTRL_CORRECT_EN
      if (ccnt0) chk("ccnt_off", ccnt0, 0);
`endif
      if (q0.size() > 0) begin
         mk = cyc - q0[0].st;
         if (mk >= 1 && mk <= ROUNDS) begin
            chk("run_round", round0, mk - 1);
            chk("run_const", const0, rc_tab[mk-1]);
            chk("run_en", {senc0, xenc0, yenc0, zenc0, sen0, xen0, yen0, zen0}, 8'hff);
            chk("run_ring", ring0, 1);
            chk("run_busy_done", {busy0, done0}, 2'b10);
         end
`ifdef ROUND_CTRL_CORRECT_EN
         if (mk == ROUNDS + 1) begin
            chk("cor_xyz", {xen0, yen0, zen0}, 3'b111);
            chk("cor_sen_enc", {sen0, senc0, xenc0, yenc0, zenc0}, 5'b0);
            chk("cor_cnt", ccnt0, q0[0].inc);
            chk("cor_ring", ring0, 0);
            chk("cor_busy_done", {busy0, done0}, 2'b10);
         end
`endif
         if (mk == LAT0) begin
            chk("done_pulse", {busy0, done0}, 2'b11);
            chk("done_round", round0, ROUNDS - 1);
            chk("done_const", const0, 6'h1a);
            chk("done_en", {senc0, xenc0, yenc0, zenc0, sen0, xen0, yen0, zen0, ring0, ccnt0}, 0);
            chk("sen_count", run_sen, ROUNDS);
            void'(q0.pop_front());
         end else if (done0) begin
            chk("done_early", done0, 0);
         end
      end else if (done0) begin
         chk("done_spurious", done0, 0);
      end
   end

   initial begin
      logic [5:0] lit [6];
      int c;
      lit[0] = 6'h01; lit[1] = 6'h03; lit[2] = 6'h07;
      lit[3] = 6'h0f; lit[4] = 6'h1f; lit[5] = 6'h3e;
      rst = 1'b1; start0 = 1'b0; inc0 = 1'b0; start1 = 1'b0; inc1 = 1'b0;
      repeat (3) step();
      chk("reset_out0", outs0, 0);
      chk("reset_out1", outs1, 0);
      rst = 1'b0;
      step();

      // single call, inc_cnt=1, starts during RUN and DONE must be ignored
      inc0 = 1'b1;
      c = cyc;
      start0 = 1'b1;
      push_txn(c, 1'b1);
      step();
      start0 = 1'b0;
      for (int i = 1; i <= LAT0 + 2; i++) begin
         if (i <= 6) chk("const_lit", const0, lit[i-1]);
         if (i == ROUNDS) chk("const_r39", const0, 6'h1a);
         if (i == 10) start0 = 1'b1;
         if (i == 11) start0 = 1'b0;
         if (i == LAT0) start0 = 1'b1;
         if (i == LAT0 + 1) begin
            start0 = 1'b0;
            chk("idle_busy", busy0, 0);
            chk("idle_clear", {round0, const0}, 0);
         end
         if (i == LAT0 + 2) chk("done_start_ignored", busy0, 0);
         step();
      end

      // single call, inc_cnt=0
      inc0 = 1'b0;
      c = cyc;
      start0 = 1'b1;
      push_txn(c, 1'b0);
      step();
      start0 = 1'b0;
      repeat (LAT0 + 1) step();

      // reset during round 7, then restart
      c = cyc;
      start0 = 1'b1;
      push_txn(c, 1'b0);
      step();
      start0 = 1'b0;
      repeat (7) step();
      chk("pre_abort_round", round0, 7);
      q0.delete();
      rst = 1'b1;
      step();
      chk("abort_out", outs0, 0);
      rst = 1'b0;
      c = cyc;
      start0 = 1'b1;
      push_txn(c, 1'b0);
      step();
      start0 = 1'b0;
      chk("restart_const", const0, 6'h01);
      repeat (LAT0) step();

      // rst wins over start
      rst = 1'b1;
      start0 = 1'b1;
      step();
      chk("rst_prio", {busy0, ring0}, 0);
      rst = 1'b0;
      start0 = 1'b0;
      step();
      chk("rst_prio_idle", busy0, 0);

      // start held high: three calls spaced latency+1 apart
      inc0 = 1'b1;
      c = cyc;
      start0 = 1'b1;
      for (int j = 0; j < 3; j++) push_txn(c + j * (LAT0 + 1), 1'b1);
      repeat (2 * (LAT0 + 1) + 1) step();
      start0 = 1'b0;
      repeat (LAT0 + 2) step();
      chk("held_drained", q0.size(), 0);

      // four phases per round
      c = cyc;
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      for (int k = 1; k <= LAT1 + 1; k++) begin
         if (k <= ROUNDS * 4) begin
            chk("ring4", ring1, 4'b0001 << ((k - 1) % 4));
            chk("en4", {sen1, xen1, yen1, zen1}, ((k - 1) % 4 == 3) ? 4'hf : 4'h0);
            chk("round4", round1, (k - 1) / 4);
         end
         if (k == ROUNDS * 4 + 1) chk("ring4_off", ring1, 0);
         if (k == LAT1 - 1) chk("done4_early", done1, 0);
         if (k == LAT1) chk("done4", {busy1, done1}, 2'b11);
         if (k == LAT1 + 1) chk("idle4", busy1, 0);
         step();
      end

      repeat (2) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
